// File: rtl/bram_reader_pkg.sv
// Shared types and sizing helpers for the 1x1 input-BRAM reader.
package bram_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int NUM_PIXELS = 5 * 5;
  localparam int ADDR_W     = $clog2(NUM_PIXELS);
  localparam int VEC_W      = 8 * 3;

  // Counter width that stays legal for a single-entry range.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo2.sv
// Two-entry FIFO holding {last, pixel} words between the BRAM and the PE stream.
module pixel_skid_fifo2 #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bram_reader_1x1.sv
// Walks the 1x1 input-map BRAM and streams pixel vectors with credit-based flow control.
// Optional BRAM_READER_MULTIPASS_EN repeats the sweep NUM_PASSES times per start.
module bram_reader_1x1
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_CHANNELS = 3,
  parameter int IN_WIDTH    = 5,
  parameter int IN_HEIGHT   = 5,
  parameter int RD_LATENCY  = 0,
  parameter int NUM_PASSES  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic [addr_w(IN_WIDTH*IN_HEIGHT)-1:0]  bram_rd_addr,
  output logic                                   bram_rd_en,
  input  logic [DATA_WIDTH*IN_CHANNELS-1:0]      bram_rd_data,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0]      o_data,
  output logic                                   o_valid,
  input  logic                                   o_ready,
  output logic                                   o_last
);

  localparam int NPIX = IN_WIDTH * IN_HEIGHT;
  localparam int AW   = addr_w(NPIX);
  localparam int VW   = DATA_WIDTH * IN_CHANNELS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
    $error("bram_reader_1x1: RD_LATENCY must be 0 or 1");
  end
  if (NUM_PASSES < 1) begin : g_bad_passes
    $error("bram_reader_1x1: NUM_PASSES must be at least 1");
  end

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [1:0]    fifo_cnt;
  logic [VW:0]   head;
  logic          inflight;
  logic          last_pass;
  logic          issue, issue_last, pop, push, push_last;
  logic [2:0]    occ;

  // A slot popped this cycle is already free for a new read.
  assign pop        = o_valid && o_ready;
  assign occ        = {1'b0, fifo_cnt} + {2'b00, inflight};
  assign issue      = (state == ST_ISSUE) && (occ < (pop ? 3'd3 : 3'd2));
  assign issue_last = last_pass && (addr == LAST_ADDR);

`ifdef BRAM_READER_MULTIPASS_EN
  localparam int PW = addr_w(NUM_PASSES);
  logic [PW-1:0] pass;

  assign last_pass = (pass == PW'(NUM_PASSES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                      pass <= '0;
    else if (state == ST_IDLE && start)           pass <= '0;
    else if (issue && addr == LAST_ADDR && !last_pass) pass <= pass + PW'(1);
  end
`else
  assign last_pass = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_ISSUE;
          addr  <= '0;
        end
        ST_ISSUE: if (issue) begin
          addr <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
          if (issue_last) state <= ST_DRAIN;
        end
        ST_DRAIN: if (!inflight && fifo_cnt == 2'd0) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  if (RD_LATENCY == 0) begin : g_lat0
    assign push      = issue;
    assign push_last = issue_last;
    assign inflight  = 1'b0;
  end else begin : g_lat1
    logic inf_last;
    // The last tag waits alongside the pending read until its data arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        inflight <= 1'b0;
        inf_last <= 1'b0;
      end else begin
        inflight <= issue;
        inf_last <= issue_last;
      end
    end
    assign push      = inflight;
    assign push_last = inf_last;
  end

  pixel_skid_fifo2 #(.W(VW + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_last, bram_rd_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign bram_rd_en   = issue;
  assign bram_rd_addr = addr;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DRAIN) && !inflight && (fifo_cnt == 2'd0);
  assign o_valid      = (fifo_cnt != 2'd0);
  assign o_data       = o_valid ? head[VW-1:0] : '0;
  assign o_last       = o_valid && head[VW];

endmodule

// File: tb/tb_bram_reader_1x1.sv
// Bench for bram_reader_1x1: one DUT per read latency, shared stimulus, queue-free array model.
module tb_bram_reader_1x1;

  localparam int N  = 25;
  localparam int AW = 5;
  localparam int VW = 24;
`ifdef BRAM_READER_MULTIPASS_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int TOTAL = N * PASSES;

  logic clk = 1'b0;
  logic rst;
  logic o_ready;
  logic [1:0] start;
  logic [1:0] busy, done, rd_en, o_valid, o_last;
  logic [AW-1:0] rd_addr [2];
  logic [VW-1:0] rd_data [2];
  logic [VW-1:0] o_data  [2];

  logic [VW-1:0] mem [N];
  logic [VW-1:0] exp_data [TOTAL];
  logic          exp_last [TOTAL];

  int compared = 0, mismatched = 0, cyc = 0;
  int n_iss[2], n_pop[2], tot_done[2], first_cyc[2], start_cyc[2], last_hs[2];
  logic prev_stall[2], prev_last[2];
  logic [VW-1:0] prev_data[2];

  typedef struct { int pct; int lat0; int lat1; bit span; } case_t;
  case_t tab[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bram_reader_1x1 #(
      .DATA_WIDTH(8), .IN_CHANNELS(3), .IN_WIDTH(5), .IN_HEIGHT(5),
      .RD_LATENCY(g), .NUM_PASSES(PASSES)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .bram_rd_addr(rd_addr[g]), .bram_rd_en(rd_en[g]), .bram_rd_data(rd_data[g]),
      .o_data(o_data[g]), .o_valid(o_valid[g]), .o_ready(o_ready), .o_last(o_last[g])
    );
  end

  // BRAM models: combinational read drives 0 when idle; registered read shows junk off-capture.
  logic          pend;
  logic [AW-1:0] paddr;
  logic [VW-1:0] junk;
  always @(posedge clk) begin
    pend  <= rd_en[1];
    paddr <= rd_addr[1];
    junk  <= VW'($urandom);
  end
  assign rd_data[0] = rd_en[0] ? mem[rd_addr[0]] : '0;
  assign rd_data[1] = pend ? mem[paddr] : junk;

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic mon();
    for (int i = 0; i < 2; i++) begin
      bit hs;
      if (rst) begin
        n_iss[i] = 0; n_pop[i] = 0; first_cyc[i] = -1; prev_stall[i] = 1'b0;
        continue;
      end
      hs = o_valid[i] && o_ready;
      if (start[i] && !busy[i]) begin
        start_cyc[i] = cyc; n_iss[i] = 0; n_pop[i] = 0; first_cyc[i] = -1;
      end
      if (rd_en[i]) begin
        chk("rd_addr", i, rd_addr[i], n_iss[i] % N);
        n_iss[i]++;
      end
      if (busy[i]) chk("credit", i, longint'((n_iss[i] - n_pop[i] - int'(hs)) <= 2), 1);
      if (prev_stall[i]) begin
        chk("stall_valid", i, o_valid[i], 1);
        chk("stall_data", i, o_data[i], prev_data[i]);
        chk("stall_last", i, o_last[i], prev_last[i]);
      end
      if (o_valid[i] && first_cyc[i] < 0) first_cyc[i] = cyc;
      if (hs) begin
        if (n_pop[i] < TOTAL) begin
          chk("o_data", i, o_data[i], exp_data[n_pop[i]]);
          chk("o_last", i, o_last[i], exp_last[n_pop[i]]);
        end else chk("extra_vec", i, n_pop[i], TOTAL - 1);
        last_hs[i] = cyc;
        n_pop[i]++;
      end
      if (done[i]) begin
        chk("done_with_hs", i, hs, 0);
        chk("done_gap", i, cyc - last_hs[i], 1);
        chk("done_count", i, n_pop[i], TOTAL);
        tot_done[i]++;
      end
      prev_stall[i] = o_valid[i] && !o_ready;
      prev_data[i]  = o_data[i];
      prev_last[i]  = o_last[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_rd_en", i, rd_en[i], 0);
      chk("rst_addr", i, rd_addr[i], 0);
      chk("rst_valid", i, o_valid[i], 0);
      chk("rst_last", i, o_last[i], 0);
      chk("rst_data", i, o_data[i], 0);
    end
  endtask

  task automatic step_rst_chk();
    @(negedge clk);
    mon();
    check_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_case(input case_t t);
    int base[2];
    base[0] = tot_done[0];
    base[1] = tot_done[1];
    for (int c = 0; c < 3000; c++) begin
      o_ready = ($urandom_range(99) < t.pct);
      for (int i = 0; i < 2; i++) start[i] = (c == 0) || (c == 4) || done[i];
      step();
      if (tot_done[0] != base[0] && tot_done[1] != base[1] && !done[0] && !done[1]) break;
    end
    start = 2'b00;
    repeat (4) step();
    for (int i = 0; i < 2; i++) begin
      chk("one_done", i, tot_done[i] - base[i], 1);
      chk("n_vectors", i, n_pop[i], TOTAL);
      chk("idle_after", i, busy[i], 0);
      chk("first_lat", i, first_cyc[i] - start_cyc[i], (i == 0) ? t.lat0 : t.lat1);
      if (t.span) chk("throughput", i, last_hs[i] - first_cyc[i], TOTAL - 1);
    end
  endtask

  initial begin
    int k, dsnap[2];
    for (int a = 0; a < N; a++) mem[a] = VW'($urandom);
    k = 0;
    for (int p = 0; p < PASSES; p++)
      for (int a = 0; a < N; a++) begin
        exp_data[k] = mem[a];
        exp_last[k] = (p == PASSES - 1) && (a == N - 1);
        k++;
      end
    for (int i = 0; i < 2; i++) begin
      n_iss[i] = 0; n_pop[i] = 0; tot_done[i] = 0; first_cyc[i] = -1;
      start_cyc[i] = 0; last_hs[i] = 0; prev_stall[i] = 1'b0;
    end
    tab[0] = '{100, 2, 3, 1'b1};
    tab[1] = '{50,  2, 3, 1'b0};
    tab[2] = '{30,  2, 3, 1'b0};
    tab[3] = '{80,  2, 3, 1'b0};

    rst = 1'b1; start = 2'b00; o_ready = 1'b0;
    step();
    step_rst_chk();
    rst = 1'b0;
    repeat (2) step();

    foreach (tab[t]) run_case(tab[t]);

    // Abort mid-run with the output stalled, then restart cleanly.
    o_ready = 1'b1;
    start = 2'b11;
    step();
    start = 2'b00;
    for (int c = 0; c < 200 && n_pop[0] < 12; c++) step();
    chk("reach_px12", 0, n_pop[0], 12);
    dsnap[0] = tot_done[0];
    dsnap[1] = tot_done[1];
    o_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step_rst_chk();
    repeat (5) step();
    for (int i = 0; i < 2; i++) begin
      chk("no_done_abort", i, tot_done[i] - dsnap[i], 0);
      chk("idle_abort", i, busy[i], 0);
    end
    run_case(tab[0]);
    run_case(tab[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
